// File: rtl/apb_initiator_if.sv
// Request/response channel plus APB requester signals for apb_initiator.
// The master modport is the initiator's view; slave is the CPU/completer side.
interface apb_initiator_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic [2:0]  req_prot;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        psel;
   logic        penable;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   modport master (
      input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
      input  pready, prdata, pslverr
   );

   modport slave (
      output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding APB3/APB4 requester: one valid/ready request becomes one APB transfer.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_initiator
`ifdef APB_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'h0
)
`endif
(
   input logic             clock,
   input logic             reset,
   apb_initiator_if.master bus
);

   // state  | meaning
   // IDLE   | req_ready high, waiting for a request
   // SETUP  | psel high, penable low (first APB cycle)
   // ACCESS | psel and penable high, waiting for pready
   // RESP   | rsp_valid high, waiting for rsp_ready
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t      state, state_nxt;

   logic        req_ready_q, req_ready_nxt;
   logic        psel_q, psel_nxt;
   logic        penable_q, penable_nxt;
   logic        pwrite_q, pwrite_nxt;
   logic [31:0] paddr_q, paddr_nxt;
   logic [31:0] pwdata_q, pwdata_nxt;
   logic [3:0]  pstrb_q, pstrb_nxt;
   logic [2:0]  pprot_q, pprot_nxt;
   logic        rsp_valid_q, rsp_valid_nxt;
   logic [31:0] rsp_rdata_q, rsp_rdata_nxt;
   logic        rsp_err_q, rsp_err_nxt;

`ifdef APB_TIMEOUT_EN
   logic [31:0] tmo_cnt, tmo_cnt_nxt;
   logic        tmo_hit;

   assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt_nxt;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         req_ready_q <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         pprot_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         req_ready_q <= req_ready_nxt;
         psel_q      <= psel_nxt;
         penable_q   <= penable_nxt;
         pwrite_q    <= pwrite_nxt;
         paddr_q     <= paddr_nxt;
         pwdata_q    <= pwdata_nxt;
         pstrb_q     <= pstrb_nxt;
         pprot_q     <= pprot_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_rdata_q <= rsp_rdata_nxt;
         rsp_err_q   <= rsp_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      req_ready_nxt = req_ready_q;
      psel_nxt      = psel_q;
      penable_nxt   = penable_q;
      pwrite_nxt    = pwrite_q;
      paddr_nxt     = paddr_q;
      pwdata_nxt    = pwdata_q;
      pstrb_nxt     = pstrb_q;
      pprot_nxt     = pprot_q;
      rsp_valid_nxt = rsp_valid_q;
      rsp_rdata_nxt = rsp_rdata_q;
      rsp_err_nxt   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_nxt   = tmo_cnt;
`endif

      unique case (state)
         S_IDLE: begin
            req_ready_nxt = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               // Reads drive zero data and strobes so the bus never carries stale write data.
               paddr_nxt     = bus.req_addr;
               pwrite_nxt    = bus.req_write;
               pwdata_nxt    = bus.req_write ? bus.req_wdata : 32'h0;
               pstrb_nxt     = bus.req_write ? bus.req_wstrb : 4'b0000;
               pprot_nxt     = bus.req_prot;
               psel_nxt      = 1'b1;
               penable_nxt   = 1'b0;
               req_ready_nxt = 1'b0;
               state_nxt     = S_SETUP;
            end
         end

         S_SETUP: begin
            penable_nxt = 1'b1;
            state_nxt   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
         end

         S_ACCESS: begin
            if (bus.pready) begin
               rsp_rdata_nxt = pwrite_q ? 32'h0 : bus.prdata;
               rsp_err_nxt   = bus.pslverr;
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               state_nxt     = S_RESP;
            end
`ifdef APB_TIMEOUT_EN
            // A completer that answers on the final allowed cycle still wins over the abort.
            else if (tmo_hit) begin
               rsp_rdata_nxt = pwrite_q ? 32'h0 : TIMEOUT_RDATA;
               rsp_err_nxt   = 1'b1;
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               state_nxt     = S_RESP;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 32'd1;
            end
`endif
         end

         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               req_ready_nxt = 1'b1;
               state_nxt     = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.req_ready = req_ready_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.pstrb     = pstrb_q;
   assign bus.pprot     = pprot_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: APB phase timing checked inline, responses checked
// against a queue of expected results filled as each request is driven.
module tb_apb_initiator;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];

   apb_initiator_if bus();

`ifdef APB_TIMEOUT_EN
   localparam logic [31:0] TMO_RDATA = 32'h0BAD_0BAD;
   apb_initiator #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(TMO_RDATA)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
`else
   apb_initiator dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
`endif

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot);
      int n = 0;
      bus.req_addr  = addr;
      bus.req_write = wr;
      bus.req_wdata = wdata;
      bus.req_wstrb = strb;
      bus.req_prot  = prot;
      bus.req_valid = 1'b1;
      while (!bus.req_ready && n < 20) begin
         tick();
         n++;
      end
      chk("req_accept", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!(bus.req_ready && !bus.rsp_valid && !bus.psel) && n < 50) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 50), 32'd1);
   endtask

   // Scoreboard: a response is consumed at the edge following a negedge with valid&&ready.
   always @(negedge clock) begin
      rsp_t e;
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
         end
      end
   end

   initial begin
      int          acc;
      int          vcnt;
      int          accepts;
      int          setups;
      int          gap;
      logic        acc_now;
      logic [31:0] addr2;
      logic        w2;

      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_write = 1'b0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      bus.req_prot  = '0;
      bus.rsp_ready = 1'b1;
      bus.pready    = 1'b1;
      bus.prdata    = '0;
      bus.pslverr   = 1'b0;

      // reset values
      tick();
      tick();
      chk("rst_psel", 32'(bus.psel), 32'd0);
      chk("rst_penable", 32'(bus.penable), 32'd0);
      chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
      chk("rst_paddr", bus.paddr, 32'd0);
      chk("rst_pwdata", bus.pwdata, 32'd0);
      chk("rst_pstrb", 32'(bus.pstrb), 32'd0);
      chk("rst_pprot", 32'(bus.pprot), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      reset = 1'b0;
      tick();

      // minimum-latency read
      bus.pready = 1'b1;
      bus.prdata = 32'h1234_5678;
      exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
      issue(32'h0000_0040, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010);
      chk("rd_setup_psel", 32'(bus.psel), 32'd1);
      chk("rd_setup_penable", 32'(bus.penable), 32'd0);
      chk("rd_setup_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rd_paddr", bus.paddr, 32'h0000_0040);
      chk("rd_pwrite", 32'(bus.pwrite), 32'd0);
      chk("rd_pstrb", 32'(bus.pstrb), 32'd0);
      chk("rd_pwdata", bus.pwdata, 32'd0);
      chk("rd_pprot", 32'(bus.pprot), 32'd2);
      tick();
      chk("rd_access_psel", 32'(bus.psel), 32'd1);
      chk("rd_access_penable", 32'(bus.penable), 32'd1);
      chk("rd_access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("rd_resp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rd_resp_psel", 32'(bus.psel), 32'd0);
      chk("rd_resp_penable", 32'(bus.penable), 32'd0);
      tick();
      chk("rd_after_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rd_after_req_ready", 32'(bus.req_ready), 32'd1);

      // write with a completer that stalls 5 cycles
      bus.pready = 1'b0;
      bus.prdata = 32'hDEAD_BEEF;
      exp_q.push_back('{rdata: 32'h0, err: 1'b0});
      issue(32'h1000_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 3'b000);
      chk("wr_setup_pwrite", 32'(bus.pwrite), 32'd1);
      tick();
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.penable) break;
         acc++;
         chk("wr_psel", 32'(bus.psel), 32'd1);
         chk("wr_paddr", bus.paddr, 32'h1000_0004);
         chk("wr_pwdata", bus.pwdata, 32'hA5A5_A5A5);
         chk("wr_pstrb", 32'(bus.pstrb), 32'h3);
         chk("wr_pwrite", 32'(bus.pwrite), 32'd1);
         if (acc == 6) bus.pready = 1'b1;
         tick();
      end
      chk("wr_access_len", acc, 32'd6);
      chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      wait_done("wr_done");

      // read error with a stalled response consumer
      bus.pready  = 1'b1;
      bus.pslverr = 1'b1;
      bus.prdata  = 32'hCAFE_F00D;
      bus.rsp_ready = 1'b0;
      exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b1});
      issue(32'h0000_0080, 1'b0, 32'h0, 4'h0, 3'b001);
      tick();
      tick();
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus.rsp_valid) break;
         vcnt++;
         chk("err_req_ready", 32'(bus.req_ready), 32'd0);
         chk("err_rsp_err", 32'(bus.rsp_err), 32'd1);
         chk("err_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
         if (vcnt == 4) bus.rsp_ready = 1'b1;
         tick();
      end
      chk("err_valid_len", vcnt, 32'd4);
      chk("err_after_req_ready", 32'(bus.req_ready), 32'd1);
      bus.pslverr = 1'b0;

      // back-to-back requests with req_valid held high
      bus.prdata = 32'h1111_2222;
      bus.req_addr  = 32'h0000_00A0;
      bus.req_write = 1'b0;
      bus.req_wdata = 32'h0;
      bus.req_wstrb = 4'h0;
      bus.req_prot  = 3'b000;
      bus.req_valid = 1'b1;
      exp_q.push_back('{rdata: 32'h1111_2222, err: 1'b0});
      accepts = 0;
      setups  = 0;
      gap     = 0;
      addr2   = '0;
      w2      = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.psel && !bus.penable) begin
            setups++;
            if (setups == 2) begin
               addr2 = bus.paddr;
               w2    = bus.pwrite;
            end
         end
         if (setups == 1 && !bus.psel) gap++;
         acc_now = bus.req_valid && bus.req_ready;
         tick();
         if (acc_now) begin
            accepts++;
            if (accepts == 1) begin
               bus.req_addr  = 32'h0000_00A4;
               bus.req_write = 1'b1;
               bus.req_wdata = 32'h5555_AAAA;
               bus.req_wstrb = 4'hF;
               exp_q.push_back('{rdata: 32'h0, err: 1'b0});
            end else begin
               bus.req_valid = 1'b0;
            end
         end
      end
      chk("b2b_accepts", accepts, 32'd2);
      chk("b2b_setups", setups, 32'd2);
      chk("b2b_gap", 32'(gap >= 1), 32'd1);
      chk("b2b_addr2", addr2, 32'h0000_00A4);
      chk("b2b_pwrite2", 32'(w2), 32'd1);

      // reset in the middle of ACCESS
      bus.pready = 1'b0;
      issue(32'h0000_00C0, 1'b0, 32'h0, 4'h0, 3'b000);
      tick();
      chk("mid_penable", 32'(bus.penable), 32'd1);
      reset = 1'b1;
      tick();
      chk("mid_rst_psel", 32'(bus.psel), 32'd0);
      chk("mid_rst_penable", 32'(bus.penable), 32'd0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_paddr", bus.paddr, 32'd0);
      reset = 1'b0;
      bus.pready = 1'b1;
      bus.prdata = 32'h0BAD_F00D;
      exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
      issue(32'h0000_00C4, 1'b0, 32'h0, 4'h0, 3'b000);
      wait_done("post_rst_done");

`ifdef APB_TIMEOUT_EN
      // completer never answers: abort after 8 ACCESS cycles
      bus.pready = 1'b0;
      exp_q.push_back('{rdata: TMO_RDATA, err: 1'b1});
      issue(32'h0000_0100, 1'b0, 32'h0, 4'h0, 3'b000);
      tick();
      acc = 0;
      for (int i = 0; i < 50; i++) begin
         if (!bus.penable) break;
         acc++;
         tick();
      end
      chk("tmo_access_len", acc, 32'd8);
      chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("tmo_rsp_err", 32'(bus.rsp_err), 32'd1);
      chk("tmo_rsp_rdata", bus.rsp_rdata, TMO_RDATA);
      wait_done("tmo_done");
      bus.pready = 1'b1;
`endif

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
